conv_stream_driver: RTL
=======================

CONV_STREAM_DRIVER -- requirements
Module: conv_stream_driver

Interface
REQ-001 SHALL have parameter IFM_N, default 196, meaning IFM pixels per frame (14x14, raster order).
REQ-002 SHALL have parameter W_N, default 9, meaning 3x3 weights per frame.
REQ-003 SHALL have parameter OFM_N, default 36, meaning pooled results expected per frame (6x6).
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning maximum idle cycles allowed between result beats.
REQ-005 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ld_en  input  1  load strobe for the source memories.
REQ-008 SHALL have port ld_sel  input  1  load target: 0 = IFM memory, 1 = weight memory.
REQ-009 SHALL have port ld_addr  input  8  load address.
REQ-010 SHALL have port ld_data  input  16  load data.
REQ-011 SHALL have port start  input  1  one-cycle frame start request.
REQ-012 SHALL have port in_valid  output  1  stream valid toward the convolution engine.
REQ-013 SHALL have port In_IFM  output  16  IFM pixel beat.
REQ-014 SHALL have port In_Weight  output  16  weight beat.
REQ-015 SHALL have port out_valid  input  1  result beat valid from the convolution engine.
REQ-016 SHALL have port Out_OFM  input  36  result beat data.
REQ-017 SHALL have port rd_addr  input  6  result buffer read address.
REQ-018 SHALL have port rd_data  output  36  result buffer read data, combinational from rd_addr.
REQ-019 SHALL have ports busy, done, err  output  1 each  status: frame active, one-cycle completion pulse, sticky error.

Function
REQ-020 SHALL implement FSM IDLE -> STREAM -> DRAIN -> IDLE.
REQ-021 IDLE: start=1 SHALL move to STREAM, clear result count, clear err; busy=1 from the next cycle.
REQ-022 STREAM: in_valid SHALL be 1 for exactly IFM_N contiguous cycles, beginning the cycle after start is sampled.
REQ-023 Beat k (0-based) SHALL drive In_IFM = IFM memory[k]; In_Weight = weight memory[k] for k < W_N, else 0.
REQ-024 After beat IFM_N-1 SHALL enter DRAIN with in_valid=0, In_IFM=0, In_Weight=0.
REQ-025 In STREAM or DRAIN, each cycle with out_valid=1 SHALL write Out_OFM to result buffer[count] and increment count (0..OFM_N).
REQ-026 When count reaches OFM_N SHALL pulse done for one cycle, drop busy, return to IDLE.
REQ-027 out_valid beats with count already OFM_N, or in IDLE, SHALL be discarded and set err.
REQ-028 DRAIN: idle counter SHALL reset on every out_valid beat; reaching TIMEOUT cycles SHALL set err, drop busy, return to IDLE without done.
REQ-029 ld_en SHALL write ld_data into the selected memory only in IDLE; ignored while busy; addresses >= IFM_N (IFM) or >= W_N (weight) ignored.
REQ-030 start while busy SHALL be ignored; start and ld_en in the same IDLE cycle SHALL perform the load and start, streaming the new value.
REQ-031 Result buffer and source memories SHALL hold contents across frames; rd_addr >= OFM_N returns 0.

Reset
REQ-032 rst_n low SHALL force IDLE, in_valid=0, In_IFM=0, In_Weight=0, busy=0, done=0, err=0, count=0, idle counter=0, asynchronously, including mid-frame.
REQ-033 Source memories and result buffer SHALL be cleared to 0 on reset.

Structure
REQ-034 IFM_N, W_N, OFM_N, TIMEOUT defaults and the FSM state encoding SHALL live in shared package conv_pkg.
REQ-035 Result capture (buffer, count, read port) SHALL be sub-module conv_result_collector.

Verification
REQ-036 Load IFM[k]=k, weights 1..9, start -> 196 contiguous in_valid cycles, beat 0 = (0,1), beat 8 = (8,9), beat 9 = (9,0).
REQ-037 Return 36 out_valid beats with Out_OFM=100+n -> done one pulse, rd_addr 5 reads 105, err=0, busy=0.
REQ-038 Return only 35 beats then silence -> err=1 exactly TIMEOUT cycles after last beat, done never asserted.
REQ-039 Return 37 beats -> first 36 stored, done pulses, err=1, buffer[0] unchanged by the extra beat.
REQ-040 Assert rst_n=0 at stream beat 50 -> in_valid=0 immediately, busy=0, next start restarts from beat 0 with cleared memories.
REQ-041 Issue start and ld_en at beat 20 -> both ignored, stream unchanged, memory unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and beat payload for the convolution stream driver.
package conv_pkg;

    localparam int unsigned IFM_N_DEF   = 196;
    localparam int unsigned W_N_DEF     = 9;
    localparam int unsigned OFM_N_DEF   = 36;
    localparam int unsigned TIMEOUT_DEF = 1024;

    localparam int unsigned LD_AW  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OFM_W  = 36;
    localparam int unsigned RD_AW  = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] ifm;
        logic [DATA_W-1:0] weight;
    } beat_t;

endpackage

// File: rtl/conv_result_collector.sv
// Captures result beats into a frame buffer and serves a combinational read port.
module conv_result_collector
    import conv_pkg::*;
#(
    parameter int unsigned OFM_N = OFM_N_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             active,
    input  logic             out_valid,
    input  logic [OFM_W-1:0] Out_OFM,
    input  logic [RD_AW-1:0] rd_addr,
    output logic [OFM_W-1:0] rd_data,
    output logic             last_c,
    output logic             overflow_c
);

    localparam int unsigned OFM_AW = $clog2(OFM_N);
    localparam int unsigned CNT_W  = $clog2(OFM_N + 1);

    logic [CNT_W-1:0] count;
    logic [OFM_W-1:0] res_buf [OFM_N];
    logic             full;
    logic             wr;

    assign full       = (count == CNT_W'(OFM_N));
    assign wr         = active && out_valid && !full;
    assign last_c     = wr && (count == CNT_W'(OFM_N - 1));
    assign overflow_c = out_valid && (!active || full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr) begin
            count <= count + CNT_W'(1);
        end
    end

    // Buffer keeps its contents across frames; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OFM_N); i++) begin
                res_buf[i] <= '0;
            end
        end else if (wr) begin
            res_buf[count[OFM_AW-1:0]] <= Out_OFM;
        end
    end

    assign rd_data = (32'(rd_addr) < OFM_N) ? res_buf[rd_addr[OFM_AW-1:0]] : '0;

endmodule

// File: rtl/conv_stream_driver.sv
// Streams IFM pixels and weights to a convolution engine and collects its pooled results.
module conv_stream_driver
    import conv_pkg::*;
#(
    parameter int unsigned IFM_N   = IFM_N_DEF,
    parameter int unsigned W_N     = W_N_DEF,
    parameter int unsigned OFM_N   = OFM_N_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic              ld_sel,
    input  logic [LD_AW-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    output logic              in_valid,
    output logic [DATA_W-1:0] In_IFM,
    output logic [DATA_W-1:0] In_Weight,
    input  logic              out_valid,
    input  logic [OFM_W-1:0]  Out_OFM,
    input  logic [RD_AW-1:0]  rd_addr,
    output logic [OFM_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned IFM_AW = $clog2(IFM_N);
    localparam int unsigned W_AW   = $clog2(W_N);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [IFM_AW-1:0] beat_q, beat_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              in_valid_d;
    logic              err_d;
    beat_t             out_d;

    logic [DATA_W-1:0] ifm_mem [IFM_N];
    logic [DATA_W-1:0] w_mem   [W_N];

    logic go_c, ld_ok_c, last_beat_c, timeout_c;
    logic res_last_c, res_over_c;

    assign go_c        = (state_q == ST_IDLE) && start;
    assign ld_ok_c     = (state_q == ST_IDLE) && ld_en;
    assign last_beat_c = (state_q == ST_STREAM) && (beat_q == IFM_AW'(IFM_N - 1));
    assign timeout_c   = (state_q == ST_DRAIN) && !out_valid && (idle_q == IDLE_W'(TIMEOUT - 1));

    conv_result_collector #(
        .OFM_N (OFM_N)
    ) u_collector (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (go_c),
        .active     (state_q != ST_IDLE),
        .out_valid  (out_valid),
        .Out_OFM    (Out_OFM),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .last_c     (res_last_c),
        .overflow_c (res_over_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        in_valid_d = 1'b0;
        out_d      = '0;
        err_d      = (go_c ? 1'b0 : err) | res_over_c | timeout_c;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (res_last_c)       state_d = ST_IDLE;
                else if (last_beat_c) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (res_last_c || timeout_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A load of address 0 in the start cycle must reach beat 0 directly.
        if (go_c) begin
            beat_d       = '0;
            in_valid_d   = 1'b1;
            out_d.ifm    = (ld_ok_c && !ld_sel && ld_addr == '0) ? ld_data : ifm_mem[0];
            out_d.weight = (ld_ok_c && ld_sel && ld_addr == '0) ? ld_data : w_mem[0];
        end else if (state_q == ST_STREAM && state_d == ST_STREAM) begin
            beat_d       = beat_q + IFM_AW'(1);
            in_valid_d   = 1'b1;
            out_d.ifm    = ifm_mem[beat_d];
            out_d.weight = (32'(beat_d) < W_N) ? w_mem[beat_d[W_AW-1:0]] : '0;
        end

        idle_d = (state_q == ST_DRAIN && state_d == ST_DRAIN && !out_valid)
                 ? idle_q + IDLE_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            idle_q    <= '0;
            in_valid  <= 1'b0;
            In_IFM    <= '0;
            In_Weight <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            idle_q    <= idle_d;
            in_valid  <= in_valid_d;
            In_IFM    <= out_d.ifm;
            In_Weight <= out_d.weight;
            busy      <= (state_d != ST_IDLE);
            done      <= res_last_c;
            err       <= err_d;
        end
    end

    // Source memories accept loads only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(IFM_N); i++) ifm_mem[i] <= '0;
            for (int i = 0; i < int'(W_N); i++)   w_mem[i]   <= '0;
        end else if (ld_ok_c) begin
            if (!ld_sel && 32'(ld_addr) < IFM_N) ifm_mem[ld_addr[IFM_AW-1:0]] <= ld_data;
            if (ld_sel && 32'(ld_addr) < W_N)    w_mem[ld_addr[W_AW-1:0]]     <= ld_data;
        end
    end

endmodule
